// File: rtl/ti_simon_seq_ctrl.sv
`default_nettype none
// ============================================================================
// ti_simon_seq_ctrl : bit-serial round/bit sequencer for a masked Simon128/128
// Rev 1.0
// ============================================================================
module ti_simon_seq_ctrl #(
    parameter int ROUNDS = 68,
    parameter int WORD   = 64
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       EN,
    input  logic       Drdy,
    output logic       BSY,
    output logic       Dvld,
    output logic       Trig,
    output logic       Ld,
    output logic       ShEn,
    output logic [5:0] BitIdx,
    output logic [6:0] Rnd,
    output logic       RndLast,
    output logic       KcBit
);

    localparam logic [61:0] Z2       = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [5:0]  BIT_LAST = 6'(WORD - 1);
    localparam logic [6:0]  RND_LAST = 7'(ROUNDS - 1);
    localparam logic [5:0]  Z_LAST   = 6'd61;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] bit_q, bit_d;
    logic [6:0] rnd_q, rnd_d;
    logic [5:0] zidx_q, zidx_d;

    logic shift;
    logic bit_wrap;

    assign shift    = (state_q == RUN) && EN;
    assign bit_wrap = (bit_q == BIT_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            bit_q   <= '0;
            rnd_q   <= '0;
            zidx_q  <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rnd_q   <= rnd_d;
            zidx_q  <= zidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rnd_d   = rnd_q;
        zidx_d  = zidx_q;
        case (state_q)
            IDLE: begin
                if (Drdy && EN) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
                bit_d   = '0;
                rnd_d   = '0;
                zidx_d  = '0;
            end
            RUN: begin
                if (shift) begin
                    if (!bit_wrap) begin
                        bit_d = bit_q + 6'd1;
                    end else if (rnd_q == RND_LAST) begin
                        // Counters return to zero here so IDLE always reads 0/0.
                        state_d = DONE;
                        bit_d   = '0;
                        rnd_d   = '0;
                        zidx_d  = '0;
                    end else begin
                        bit_d  = '0;
                        rnd_d  = rnd_q + 7'd1;
                        zidx_d = (zidx_q == Z_LAST) ? 6'd0 : zidx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BSY     = (state_q != IDLE);
    assign Ld      = (state_q == LOAD);
    assign Dvld    = (state_q == DONE);
    assign Trig    = (state_q == RUN) && (rnd_q == 7'd0);
    assign ShEn    = shift;
    assign RndLast = shift && bit_wrap;
    assign BitIdx  = bit_q;
    assign Rnd     = rnd_q;

    // Round constant c XOR z2: c = 2^64-4 gives bit0 = 0, bit1 = 0, upper bits 1.
    always_comb begin
        if (bit_q == 6'd0) begin
            KcBit = Z2[Z_LAST - zidx_q];
        end else if (bit_q == 6'd1) begin
            KcBit = 1'b0;
        end else begin
            KcBit = 1'b1;
        end
    end

endmodule
`default_nettype wire
